cpu_halt_ctrl: RTL and testbench

CPU-side responder to the Maria bus-master signals. It sits between Maria and the 6502 core (T65). It turns Maria's `halt_b`, `ready` and `int_b` outputs, together with the `pclk0`/`pclk1` phase strobes, into a per-cycle CPU clock enable, a RDY level and a stretched NMI. It returns `bus_released` to Maria, which uses it as `halt_unlock`, so that DMA begins only once the CPU has been parked at a cycle boundary.

---
 rtl/atari7800_cpu_pkg.sv | 17 +
 rtl/nmi_stretcher.sv | 52 +++++
 rtl/cpu_halt_ctrl.sv | 113 +++++++++++
 tb/tb_cpu_halt_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/atari7800_cpu_pkg.sv
// Shared types and default constants for the Atari 7800 CPU-side halt controller.
//   cpu_state_t    : halt handshake states
//   NMI_CYCLES_DEF : CPU cycles for which NMI is held low
//   STALL_CNT_W    : width of the undelivered-pclk1 counter
package atari7800_cpu_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted,
    StResume
  } cpu_state_t;

  localparam int unsigned NMI_CYCLES_DEF = 2;
  localparam int unsigned STALL_CNT_W    = 13;

endpackage

// File: rtl/nmi_stretcher.sv
// Stretches Maria's DLI request into an NMI that stays low for NMI_CYCLES enabled CPU cycles.
//   clk_sys   : system clock
//   reset_b   : asynchronous active-low reset
//   int_b     : DLI request, active low
//   cpu_ce    : CPU cycle enable; each pulse consumes one NMI cycle
//   cpu_nmi_n : NMI to the CPU, active low, registered
module nmi_stretcher
  import atari7800_cpu_pkg::*;
#(
  parameter int unsigned NMI_CYCLES = NMI_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic reset_b,
  input  logic int_b,
  input  logic cpu_ce,
  output logic cpu_nmi_n
);

  localparam int unsigned CntW    = (NMI_CYCLES < 2) ? 1 : $clog2(NMI_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(NMI_CYCLES);

  logic            int_b_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            nmi_n_d, nmi_n_q;

  // The countdown only moves on cpu_ce, so it freezes while the CPU is parked.
  // Edges arriving while it is non-zero are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      if (cpu_ce) cnt_d = cnt_q - CntW'(1);
    end else if (int_b_q && !int_b) begin
      cnt_d = CntLoad;
    end
    nmi_n_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_sys or negedge reset_b) begin
    if (!reset_b) begin
      int_b_q <= 1'b1;
      cnt_q   <= '0;
      nmi_n_q <= 1'b1;
    end else begin
      int_b_q <= int_b;
      cnt_q   <= cnt_d;
      nmi_n_q <= nmi_n_d;
    end
  end

  assign cpu_nmi_n = nmi_n_q;

endmodule

// File: rtl/cpu_halt_ctrl.sv
// CPU-side responder to Maria's bus-master signals: produces the 6502 clock enable, RDY and a
// stretched NMI, and reports when the CPU is parked so Maria may start DMA.
//   clk_sys, reset_b   : clock and asynchronous active-low reset
//   pclk0, pclk1       : one-clock phase strobes from Maria
//   halt_b, ready      : DMA request (low) and WSYNC stall (low)
//   int_b, lrc         : DLI request (low) and line-restart counter clear
//   cpu_rw             : current CPU cycle direction (1 = read)
//   cpu_ce             : combinational one-clock CPU cycle enable, aligned to pclk1
//   cpu_rdy, cpu_nmi_n : registered RDY and stretched NMI
//   bus_released       : CPU parked, feeds Maria halt_unlock
//   stall_ticks        : saturating count of pclk1 strobes not delivered since lrc
module cpu_halt_ctrl
  import atari7800_cpu_pkg::*;
#(
  parameter int unsigned NMI_CYCLES = NMI_CYCLES_DEF,
  parameter int unsigned CNT_W      = STALL_CNT_W
) (
  input  logic             clk_sys,
  input  logic             reset_b,
  input  logic             pclk0,
  input  logic             pclk1,
  input  logic             halt_b,
  input  logic             ready,
  input  logic             int_b,
  input  logic             lrc,
  input  logic             cpu_rw,
  output logic             cpu_ce,
  output logic             cpu_rdy,
  output logic             cpu_nmi_n,
  output logic             bus_released,
  output logic [CNT_W-1:0] stall_ticks
);

  cpu_state_t       state_d, state_q;
  logic             bus_released_d, bus_released_q;
  logic             cpu_rdy_q;
  logic [CNT_W-1:0] stall_d, stall_q;
  logic             rdy_stall;

  always_comb begin
    // 6502 RDY only holds read cycles; writes always proceed.
    rdy_stall      = !cpu_rdy_q && cpu_rw;
    cpu_ce         = 1'b0;
    state_d        = state_q;
    bus_released_d = bus_released_q;
    unique case (state_q)
      StRun: begin
        if (pclk1) begin
          cpu_ce = !rdy_stall;
          if (!halt_b) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pclk0) begin
          state_d        = StHalted;
          bus_released_d = 1'b1;
        end
      end
      StHalted: begin
        if (halt_b) begin
          state_d        = StResume;
          bus_released_d = 1'b0;
        end
      end
      StResume: begin
        // A fresh halt request before the first pclk1 parks again without running a cycle.
        if (!halt_b) begin
          state_d = StDrain;
        end else if (pclk1) begin
          cpu_ce  = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    stall_d = stall_q;
    if (lrc) begin
      stall_d = '0;
    end else if (pclk1 && !cpu_ce && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= StRun;
      bus_released_q <= 1'b0;
      cpu_rdy_q      <= 1'b1;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      bus_released_q <= bus_released_d;
      cpu_rdy_q      <= ready;
      stall_q        <= stall_d;
    end
  end

  nmi_stretcher #(
    .NMI_CYCLES(NMI_CYCLES)
  ) u_nmi_stretcher (
    .clk_sys  (clk_sys),
    .reset_b  (reset_b),
    .int_b    (int_b),
    .cpu_ce   (cpu_ce),
    .cpu_nmi_n(cpu_nmi_n)
  );

  assign cpu_rdy      = cpu_rdy_q;
  assign bus_released = bus_released_q;
  assign stall_ticks  = stall_q;

endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// Bench for cpu_halt_ctrl: vector table for handshake/WSYNC/NMI corners, hand sequences for
// reset mid-halt and counter saturation, then randomized Maria-like traffic vs a flag model.
module tb_cpu_halt_ctrl;

  localparam int unsigned NmiCycles = 2;
  localparam int unsigned CntW      = 4;
  localparam int          StallMax  = 15;

  logic            clk_sys;
  logic            reset_b;
  logic            pclk0, pclk1, halt_b, ready, int_b, lrc, cpu_rw;
  logic            cpu_ce, cpu_rdy, cpu_nmi_n, bus_released;
  logic [CntW-1:0] stall_ticks;

  cpu_halt_ctrl #(
    .NMI_CYCLES(NmiCycles),
    .CNT_W     (CntW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_b     (reset_b),
    .pclk0       (pclk0),
    .pclk1       (pclk1),
    .halt_b      (halt_b),
    .ready       (ready),
    .int_b       (int_b),
    .lrc         (lrc),
    .cpu_rw      (cpu_rw),
    .cpu_ce      (cpu_ce),
    .cpu_rdy     (cpu_rdy),
    .cpu_nmi_n   (cpu_nmi_n),
    .bus_released(bus_released),
    .stall_ticks (stall_ticks)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic p0, p1, hb, rd, ib, lrc, rw;
    logic ce, rdy, nmi, rel;
    int   stall;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the CPU is either running, draining, parked or resuming (flags).
  bit m_drain, m_park, m_resume, m_rdy, m_int_prev;
  int m_nmi_left, m_stall;

  function automatic void add(input logic p0, p1, hb, rd, ib, l, rw,
                              input logic ce, rdy, nmi, rel, input int st);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.hb = hb; v.rd = rd; v.ib = ib; v.lrc = l; v.rw = rw;
    v.ce = ce; v.rdy = rdy; v.nmi = nmi; v.rel = rel; v.stall = st;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 0; m_park = 0; m_resume = 0;
    m_rdy = 1; m_int_prev = 1; m_nmi_left = 0; m_stall = 0;
  endtask

  function automatic bit model_ce(input logic p1, hb, rw);
    if (!p1 || m_drain || m_park) return 1'b0;
    if (m_resume) return hb;
    return !(!m_rdy && rw);
  endfunction

  task automatic model_step(input vec_t v, input bit ce);
    bit run, nd, np, nr;
    run = !(m_drain || m_park || m_resume);
    nd = m_drain; np = m_park; nr = m_resume;
    if (run && v.p1 && !v.hb) nd = 1;
    if (m_drain && v.p0) begin nd = 0; np = 1; end
    if (m_park && v.hb) begin np = 0; nr = 1; end
    if (m_resume) begin
      if (!v.hb) begin nr = 0; nd = 1; end
      else if (v.p1) nr = 0;
    end
    m_drain = nd; m_park = np; m_resume = nr;
    if (v.lrc) m_stall = 0;
    else if (v.p1 && !ce && m_stall < StallMax) m_stall++;
    if (m_nmi_left > 0) begin
      if (ce) m_nmi_left--;
    end else if (m_int_prev && !v.ib) begin
      m_nmi_left = NmiCycles;
    end
    m_int_prev = v.ib;
    m_rdy = v.rd;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic tick(input vec_t v, input bit use_tab, input string tag, output bit ce_seen);
    bit ce_exp;
    pclk0 = v.p0; pclk1 = v.p1; halt_b = v.hb; ready = v.rd;
    int_b = v.ib; lrc = v.lrc; cpu_rw = v.rw;
    #1;
    ce_exp  = model_ce(v.p1, v.hb, v.rw);
    ce_seen = cpu_ce;
    check({tag, " cpu_ce"}, int'(cpu_ce), int'(ce_exp));
    if (use_tab) check({tag, " tab cpu_ce"}, int'(cpu_ce), int'(v.ce));
    @(posedge clk_sys);
    model_step(v, ce_exp);
    #1;
    check({tag, " bus_released"}, int'(bus_released), int'(m_park));
    check({tag, " cpu_rdy"}, int'(cpu_rdy), int'(m_rdy));
    check({tag, " cpu_nmi_n"}, int'(cpu_nmi_n), int'(m_nmi_left == 0));
    check({tag, " stall_ticks"}, int'(stall_ticks), m_stall);
    if (use_tab) begin
      check({tag, " tab bus_released"}, int'(bus_released), int'(v.rel));
      check({tag, " tab cpu_rdy"}, int'(cpu_rdy), int'(v.rdy));
      check({tag, " tab cpu_nmi_n"}, int'(cpu_nmi_n), int'(v.nmi));
      check({tag, " tab stall_ticks"}, int'(stall_ticks), v.stall);
    end
  endtask

  function automatic vec_t mk(input logic p0, p1, hb, rd, ib, l, rw);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.hb = hb; v.rd = rd; v.ib = ib; v.lrc = l; v.rw = rw;
    v.ce = 0; v.rdy = 0; v.nmi = 0; v.rel = 0; v.stall = 0;
    return v;
  endfunction

  task automatic phase_pairs(input int n, input logic rd, output int ce_cnt);
    bit c;
    ce_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick(mk(1, 0, 1, rd, 1, 0, 1), 0, "run p0", c);
      tick(mk(0, 1, 1, rd, 1, 0, 1), 0, "run p1", c);
      if (c) ce_cnt++;
    end
  endtask

  initial begin
    int  ce_cnt;
    bit  c;
    int  cyc;
    logic hb, rd;

    //   p0 p1 hb rd ib lrc rw | ce rdy nmi rel stall
    add(1, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0);  // free run
    add(0, 1, 1, 1, 1, 0, 1,  1, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 0, 0);  // halt_b drops before pclk1
    add(0, 1, 0, 1, 1, 0, 1,  1, 1, 1, 0, 0);  // last cycle still runs -> drain
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 1, 0);  // pclk0 ends drain
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0);  // unlock
    add(1, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1,  1, 1, 1, 0, 0);  // first pclk1 after unlock
    add(1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 0);  // WSYNC
    add(0, 1, 1, 0, 1, 0, 1,  0, 0, 1, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 1);
    add(0, 1, 1, 0, 1, 0, 1,  0, 0, 1, 0, 2);
    add(1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 2);
    add(0, 1, 1, 0, 1, 0, 1,  0, 0, 1, 0, 3);
    add(1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 3);
    add(0, 1, 1, 0, 1, 0, 0,  1, 0, 1, 0, 3);  // write proceeds
    add(1, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0, 3);
    add(0, 1, 1, 0, 1, 1, 1,  0, 0, 1, 0, 0);  // lrc beats increment
    add(1, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1,  1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 0);  // NMI across halt
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 1,  1, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1,  0, 1, 0, 1, 0);
    add(0, 0, 1, 1, 1, 0, 1,  0, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 1,  0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1,  1, 1, 1, 0, 0);  // NMI released after resume cycle
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 0, 0);  // re-halt in RESUME
    add(0, 1, 0, 1, 1, 0, 1,  1, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 1, 0, 1,  0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1,  0, 1, 1, 0, 0);
    add(0, 1, 0, 1, 1, 0, 1,  0, 1, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 1,  0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1,  0, 1, 0, 1, 1);  // NMI loaded while parked

    reset_b = 0;
    pclk0 = 0; pclk1 = 0; halt_b = 1; ready = 1; int_b = 1; lrc = 0; cpu_rw = 1;
    model_reset();
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check("reset cpu_ce", int'(cpu_ce), 0);
    check("reset cpu_rdy", int'(cpu_rdy), 1);
    check("reset cpu_nmi_n", int'(cpu_nmi_n), 1);
    check("reset bus_released", int'(bus_released), 0);
    check("reset stall_ticks", int'(stall_ticks), 0);
    reset_b = 1;

    foreach (vecs[i]) tick(vecs[i], 1, $sformatf("row%0d", i), c);

    // Reset while parked: the bus is released without waiting for a clock.
    reset_b = 0;
    #1;
    check("async reset bus_released", int'(bus_released), 0);
    check("async reset cpu_nmi_n", int'(cpu_nmi_n), 1);
    check("async reset stall_ticks", int'(stall_ticks), 0);
    model_reset();
    @(posedge clk_sys);
    #1;
    reset_b = 1;

    phase_pairs(10, 1'b1, ce_cnt);
    check("free run ce count", ce_cnt, 10);
    check("free run stall_ticks", int'(stall_ticks), 0);

    phase_pairs(20, 1'b0, ce_cnt);
    check("saturate ce count", ce_cnt, 0);
    check("saturate stall_ticks", int'(stall_ticks), StallMax);
    tick(mk(1, 0, 1, 1, 1, 1, 1), 0, "lrc clear", c);
    check("lrc clear stall_ticks", int'(stall_ticks), 0);

    // Randomized Maria-like traffic; pclk1 is withheld while the bus is released.
    hb = 1; rd = 1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      vec_t v;
      if ($urandom_range(0, 15) == 0) hb = ~hb;
      if ($urandom_range(0, 7) == 0) rd = ~rd;
      v = mk((cyc % 4) == 0, ((cyc % 4) == 2) && !m_park, hb, rd,
             $urandom_range(0, 31) != 0, $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)));
      tick(v, 0, $sformatf("rand%0d", cyc), c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
